// File: rtl/edge_detect_pkg.sv
// Shared types and constants for the frame-buffer sequencing path that feeds the Sobel stage.
package edge_detect_pkg;

  // Line tracking state of the sequencer.
  typedef enum logic [1:0] {
    S_WAIT_FRAME = 2'd0,
    S_BLANK      = 2'd1,
    S_LINE       = 2'd2
  } seq_state_e;

  // Number of physical rows held by the line buffer.
  localparam int unsigned BUF_ROWS = 4;

  // The 3x3 matrix is complete once the pixel two rows/columns past the origin is written.
  localparam int unsigned MATRIX_MIN_COL = 2;
  localparam int unsigned MATRIX_MIN_ROW = 2;

  // Cycle offsets of each strobe relative to the detected pixel-clock edge.
  localparam int unsigned STROBE_WR_OFFSET    = 1;
  localparam int unsigned STROBE_RD_OFFSET    = 2;
  localparam int unsigned STROBE_VALID_OFFSET = 3;

endpackage

// File: rtl/pixel_clock_edge_sync.sv
// Brings the VGA pixel clock and data-valid into the system clock domain as plain data and
// flags each rising edge of the synchronized pixel clock.
module pixel_clock_edge_sync #(
  parameter int unsigned P_SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_pixel_clk,
  input  logic i_data_valid,
  output logic o_pixel_edge,
  output logic o_data_valid
);

  logic [P_SYNC_STAGES-1:0] r_pclk_sync;
  logic [P_SYNC_STAGES-1:0] r_de_sync;
  logic                     r_pclk_prev;

  // Identical chains keep data-valid aligned with the pixel clock it belongs to.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_pclk_sync <= '0;
      r_de_sync   <= '0;
      r_pclk_prev <= 1'b0;
    end else begin
      r_pclk_sync <= {r_pclk_sync[P_SYNC_STAGES-2:0], i_pixel_clk};
      r_de_sync   <= {r_de_sync[P_SYNC_STAGES-2:0], i_data_valid};
      r_pclk_prev <= r_pclk_sync[P_SYNC_STAGES-1];
    end
  end

  assign o_pixel_edge = r_pclk_sync[P_SYNC_STAGES-1] & ~r_pclk_prev;
  assign o_data_valid = r_de_sync[P_SYNC_STAGES-1];

endmodule

// File: rtl/frame_buffer_sequencer.sv
// Sequences the 4-row grayscale line buffer: tracks frame column/row from the sampled VGA
// timing, issues write then read strobes per pixel, and flags complete 3x3 matrices.
module frame_buffer_sequencer
  import edge_detect_pkg::*;
#(
  parameter int unsigned P_FRAME_COLUMNS     = 640,
  parameter int unsigned P_FRAME_ROWS        = 480,
  parameter int unsigned P_FRAME_COLUMN_BITS = $clog2(P_FRAME_COLUMNS),
  parameter int unsigned P_FRAME_ROW_BITS    = $clog2(P_FRAME_ROWS),
  parameter int unsigned P_BUF_ROW_BITS      = 2,
  parameter int unsigned P_SYNC_STAGES       = 2
) (
  input  logic                           I_CLK,
  input  logic                           I_RESET_N,
  input  logic                           I_PIXEL_CLK,
  input  logic                           I_DATA_VALID,
  output logic [P_FRAME_COLUMN_BITS-1:0] O_BUF_COLUMN,
  output logic [P_BUF_ROW_BITS-1:0]      O_BUF_ROW,
  output logic                           O_BUF_WRITE_ENABLE,
  output logic                           O_BUF_READ_ENABLE,
  output logic                           O_MATRIX_VALID,
  output logic [P_FRAME_COLUMN_BITS-1:0] O_MATRIX_COLUMN,
  output logic [P_FRAME_ROW_BITS-1:0]    O_MATRIX_ROW,
  output logic                           O_FRAME_DONE,
  output logic                           O_LINE_ERROR
);

  // One guard bit so the counter can reach P_FRAME_COLUMNS and expose overlong lines.
  localparam int unsigned L_COL_W = P_FRAME_COLUMN_BITS + 1;
  localparam logic [L_COL_W-1:0]          L_COL_LIMIT = L_COL_W'(P_FRAME_COLUMNS);
  localparam logic [P_FRAME_ROW_BITS-1:0] L_LAST_ROW  = P_FRAME_ROW_BITS'(P_FRAME_ROWS - 1);

  logic w_pixel_edge;
  logic w_data_valid;

  seq_state_e                  r_state, w_state_next;
  logic [L_COL_W-1:0]          r_col, w_col_next;
  logic [P_FRAME_ROW_BITS-1:0] r_row, w_row_next;
  logic                        r_line_error, w_line_error_next;
  logic                        w_write_fire;
  logic                        w_frame_done_fire;
  logic [P_BUF_ROW_BITS-1:0]   w_buf_row;
  logic                        w_in_window;

  logic [P_FRAME_COLUMN_BITS-1:0] r_buf_column;
  logic [P_BUF_ROW_BITS-1:0]      r_buf_row;
  logic [P_FRAME_ROW_BITS-1:0]    r_pixel_row;
  logic [STROBE_VALID_OFFSET-1:STROBE_WR_OFFSET] r_strobe_pipe;
  logic                           r_frame_done;
  logic                           r_matrix_valid;
  logic [P_FRAME_COLUMN_BITS-1:0] r_matrix_column;
  logic [P_FRAME_ROW_BITS-1:0]    r_matrix_row;

  pixel_clock_edge_sync #(
    .P_SYNC_STAGES (P_SYNC_STAGES)
  ) u_edge_sync (
    .i_clk        (I_CLK),
    .i_reset_n    (I_RESET_N),
    .i_pixel_clk  (I_PIXEL_CLK),
    .i_data_valid (I_DATA_VALID),
    .o_pixel_edge (w_pixel_edge),
    .o_data_valid (w_data_valid)
  );

  assign w_buf_row = P_BUF_ROW_BITS'(r_row % BUF_ROWS);

  // Next-state: act only on pixel-clock edges; line ends advance the row and close the frame.
  always_comb begin
    w_state_next      = r_state;
    w_col_next        = r_col;
    w_row_next        = r_row;
    w_line_error_next = r_line_error;
    w_write_fire      = 1'b0;
    w_frame_done_fire = 1'b0;
    if (w_pixel_edge) begin
      unique case (r_state)
        S_WAIT_FRAME: begin
          // Only a blanking edge proves we are not joining a line half-way through.
          if (!w_data_valid) w_state_next = S_BLANK;
        end
        S_BLANK: begin
          if (w_data_valid) begin
            w_write_fire = 1'b1;
            w_col_next   = r_col + L_COL_W'(1);
            w_state_next = S_LINE;
          end
        end
        S_LINE: begin
          if (w_data_valid) begin
            if (r_col < L_COL_LIMIT) begin
              w_write_fire = 1'b1;
              w_col_next   = r_col + L_COL_W'(1);
            end else begin
              // Saturated: excess pixels are dropped and the line is marked bad.
              w_line_error_next = 1'b1;
            end
          end else begin
            if (r_col != L_COL_LIMIT) w_line_error_next = 1'b1;
            w_col_next   = '0;
            w_state_next = S_BLANK;
            if (r_row == L_LAST_ROW) begin
              w_row_next        = '0;
              w_frame_done_fire = 1'b1;
            end else begin
              w_row_next = r_row + P_FRAME_ROW_BITS'(1);
            end
          end
        end
        default: w_state_next = S_WAIT_FRAME;
      endcase
    end
  end

  // State, counters and the sticky line error.
  always_ff @(posedge I_CLK or negedge I_RESET_N) begin
    if (!I_RESET_N) begin
      r_state      <= S_WAIT_FRAME;
      r_col        <= '0;
      r_row        <= '0;
      r_line_error <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_col        <= w_col_next;
      r_row        <= w_row_next;
      r_line_error <= w_line_error_next;
      r_frame_done <= w_frame_done_fire;
    end
  end

  // Buffer address is captured with the write and held through the following read.
  always_ff @(posedge I_CLK or negedge I_RESET_N) begin
    if (!I_RESET_N) begin
      r_buf_column  <= '0;
      r_buf_row     <= '0;
      r_pixel_row   <= '0;
      r_strobe_pipe <= '0;
    end else begin
      if (w_write_fire) begin
        r_buf_column <= r_col[P_FRAME_COLUMN_BITS-1:0];
        r_buf_row    <= w_buf_row;
        r_pixel_row  <= r_row;
      end
      r_strobe_pipe <= {r_strobe_pipe[STROBE_RD_OFFSET-1:STROBE_WR_OFFSET], w_write_fire};
    end
  end

  assign w_in_window = (r_buf_column >= P_FRAME_COLUMN_BITS'(MATRIX_MIN_COL)) &&
                       (r_pixel_row >= P_FRAME_ROW_BITS'(MATRIX_MIN_ROW));

  // Matrix becomes valid the cycle after the read; the centre is one row/column behind.
  always_ff @(posedge I_CLK or negedge I_RESET_N) begin
    if (!I_RESET_N) begin
      r_matrix_valid  <= 1'b0;
      r_matrix_column <= '0;
      r_matrix_row    <= '0;
    end else begin
      r_matrix_valid <= r_strobe_pipe[STROBE_RD_OFFSET] & w_in_window;
      if (r_strobe_pipe[STROBE_RD_OFFSET] && w_in_window) begin
        r_matrix_column <= r_buf_column - P_FRAME_COLUMN_BITS'(1);
        r_matrix_row    <= r_pixel_row - P_FRAME_ROW_BITS'(1);
      end
    end
  end

  assign O_BUF_COLUMN       = r_buf_column;
  assign O_BUF_ROW          = r_buf_row;
  assign O_BUF_WRITE_ENABLE = r_strobe_pipe[STROBE_WR_OFFSET];
  assign O_BUF_READ_ENABLE  = r_strobe_pipe[STROBE_RD_OFFSET];
  assign O_MATRIX_VALID     = r_matrix_valid;
  assign O_MATRIX_COLUMN    = r_matrix_column;
  assign O_MATRIX_ROW       = r_matrix_row;
  assign O_FRAME_DONE       = r_frame_done;
  assign O_LINE_ERROR       = r_line_error;

endmodule
